// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   state_t   : controller state encoding (RUN / MD_BUSY)
//   REG_ZERO  : hard-wired zero register number, never a hazard source
//   NOP_INSN  : instruction word loaded into a flushed pipeline register
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_stall_counter.sv
// hazard_stall_counter: saturating up-counter of stall cycles.
// Ports:
//   clk    : clock, counts on the falling edge
//   reset  : asynchronous, active-low clear
//   inc    : count enable for this edge
//   count  : current value, holds at all-ones
module hazard_stall_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] count
);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {CW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Resolves load-use (one bubble), taken branches in EX (squash IF/ID and
// ID/EX) and multi-cycle mult/div (front end frozen for MD_LAT-1 cycles).
// Ports:
//   clk, reset                    : clock (falling-edge state), async active-low reset
//   id_rs, id_rt, id_uses_rt      : source operands of the ID instruction
//   ex_mem_read, ex_rt            : EX instruction is a load, and its destination
//   ex_branch_taken               : branch/jump in EX resolved taken
//   ex_md_start                   : EX instruction is mult/div
//   pc_en .. memwb_en, *_flush    : pipeline register enables and clears
//   md_busy                       : controller is in MD_BUSY
//   stall_cycles                  : saturating count of cycles with pc_en=0
//
// state   | meaning
// RUN     | normal flow; branch, mult/div start and load-use resolved here
// MD_BUSY | mult/div occupying EX; front end frozen until md_cnt reaches 0
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic          id_uses_rt,
    input  logic          ex_mem_read,
    input  logic [4:0]    ex_rt,
    input  logic          ex_branch_taken,
    input  logic          ex_md_start,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          ifid_flush,
    output logic          idex_en,
    output logic          idex_flush,
    output logic          exmem_en,
    output logic          exmem_flush,
    output logic          memwb_en,
    output logic          md_busy,
    output logic [CW-1:0] stall_cycles
);

    // The start cycle itself is one stall cycle, so the counter is loaded
    // with MD_LAT-2 to give MD_LAT-1 frozen cycles in total.
    localparam bit         MD_STALLS = (MD_LAT > 1);
    localparam logic [3:0] MD_INIT   = (MD_LAT > 1) ? 4'(MD_LAT - 2) : 4'd0;

    state_t     state, state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            md_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        md_busy     = 1'b0;

        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_md_start && MD_STALLS) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    state_nxt   = MD_BUSY;
                    md_cnt_nxt  = MD_INIT;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                if (md_cnt != 4'd0) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    md_cnt_nxt  = md_cnt - 4'd1;
                end else begin
                    // mult/div moves to MEM on this edge, so it cannot retrigger
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (!reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_flush  = 1'b0;
            exmem_en    = 1'b0;
            exmem_flush = 1'b0;
            memwb_en    = 1'b0;
            md_busy     = 1'b0;
        end
    end

    hazard_stall_counter #(
        .CW(CW)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (reset && !pc_en),
        .count (stall_cycles)
    );

endmodule
